// File: rtl/gate_model_tester.sv
// rtl/gate_model_tester.sv - exhaustive stimulus generator with MISR response compaction
module gate_model_tester #(
  parameter int IN_W   = 11,
  parameter int OUT_W  = 10,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       golden_sig,
  input  logic [OUT_W-1:0]  resp,
  output logic [IN_W-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [IN_W-1:0]   r_stim;
  logic [15:0]       r_sig;
  logic [3:0]        r_wait;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [15:0]       w_resp_ext;
  logic [15:0]       w_sig_next;
  logic              w_stim_last;

  assign w_resp_ext  = 16'(resp);
  assign w_sig_next  = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ w_resp_ext;
  assign w_stim_last = &r_stim;

  // Run controller: sequences every input vector, settles, compresses the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stim  <= '0;
      r_sig   <= 16'h0000;
      r_wait  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // A simultaneous abort cancels the start request.
          if (start && !abort) begin
            r_stim  <= '0;
            r_sig   <= 16'hFFFF;
            r_wait  <= SETTLE_CNT;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Signature is deliberately left untouched so the partial result is visible.
            r_stim  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_sig <= w_sig_next;
            if (!w_stim_last) begin
              r_stim <= r_stim + IN_W'(1);
              r_wait <= SETTLE_CNT;
            end else begin
              // Last vector stays on stim; the counter never wraps inside a run.
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_pass  <= (r_sig == golden_sig);
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stim      = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_gate_model_tester.sv
// tb/tb_gate_model_tester.sv - directed bench for gate_model_tester
module tb_gate_model_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n_a, start_a, abort_a, resp_mode;
  logic [15:0] golden_a, sig_a;
  logic [9:0]  resp_a;
  logic [10:0] stim_a;
  logic        busy_a, done_a, pass_a;

  // Minimal instance: IN_W=1, SETTLE=0
  logic        rst_n_b, start_b, abort_b;
  logic [15:0] golden_b, sig_b;
  logic [9:0]  resp_b;
  logic [0:0]  stim_b;
  logic        busy_b, done_b, pass_b;

  assign resp_a = resp_mode ? stim_a[10:1] : 10'd0;
  assign resp_b = 10'd0;

  gate_model_tester dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
    .golden_sig(golden_a), .resp(resp_a), .stim(stim_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  gate_model_tester #(.IN_W(1), .OUT_W(10), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
    .golden_sig(golden_b), .resp(resp_b), .stim(stim_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  int total = 0;
  int bad   = 0;
  int nbusy, ndone, nerr;
  logic [15:0] sig_hold;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference signature of a complete default run.
  function automatic logic [15:0] misr_model(input bit use_stim);
    logic [15:0] s;
    logic [15:0] r;
    s = 16'hFFFF;
    for (int v = 0; v < 2048; v++) begin
      r = use_stim ? 16'((v >> 1) & 32'h3FF) : 16'h0000;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    end
    return s;
  endfunction

  // Pulses start and follows a default run until busy drops (bounded).
  task automatic run_a(input bit repulse, output int nb, output int nd, output int ne);
    nb = 0; nd = 0; ne = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    while (busy_a && nb < 7000) begin
      if (stim_a !== 11'(nb / 3)) ne++;
      if (done_a) nd++;
      start_a = repulse && (nb == 500 || nb == 3000);
      nb++;
      step();
    end
    start_a = 1'b0;
  endtask

  initial begin
    rst_n_a = 0; start_a = 0; abort_a = 0; resp_mode = 0; golden_a = 16'h0;
    rst_n_b = 0; start_b = 0; abort_b = 0; golden_b = 16'hCF9F;
    step(); step();

    check("rst_sig", sig_a, 16'h0000);
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig_b", sig_b, 16'h0000);

    // Minimal instance: two vectors, signature EFDF then CF9F.
    rst_n_a = 1; rst_n_b = 1;
    start_b = 1; step(); start_b = 0;
    check("b_busy0", busy_b, 1);
    check("b_stim0", stim_b, 0);
    check("b_sig_init", sig_b, 16'hFFFF);
    step();
    check("b_busy1", busy_b, 1);
    check("b_stim1", stim_b, 1);
    check("b_sig1", sig_b, 16'hEFDF);
    step();
    check("b_done", done_b, 1);
    check("b_busy_done", busy_b, 0);
    check("b_sig2", sig_b, 16'hCF9F);
    check("b_stim_hold", stim_b, 1);
    step();
    check("b_done_off", done_b, 0);
    check("b_pass1", pass_b, 1);

    // Same run against a wrong golden value.
    golden_b = 16'h0000;
    start_b = 1; step(); start_b = 0;
    step(); step();
    check("b2_done", done_b, 1);
    step();
    check("b2_pass0", pass_b, 0);
    check("b2_sig", sig_b, 16'hCF9F);

    // Full default run, resp tied low.
    golden_a = misr_model(1'b0);
    run_a(1'b0, nbusy, ndone, nerr);
    check("a1_busy_cycles", nbusy, 6144);
    check("a1_stim_steps", nerr, 0);
    check("a1_no_early_done", ndone, 0);
    check("a1_done", done_a, 1);
    check("a1_stim_last", stim_a, 11'h7FF);
    step();
    check("a1_done_once", done_a, 0);
    check("a1_pass", pass_a, 1);
    check("a1_sig", sig_a, misr_model(1'b0));

    // Abort 100 cycles after start.
    start_a = 1; step(); start_a = 0;
    repeat (99) step();
    sig_hold = sig_a;
    abort_a = 1; step(); abort_a = 0;
    check("ab_busy", busy_a, 0);
    check("ab_stim", stim_a, 0);
    check("ab_pass", pass_a, 0);
    check("ab_sig_hold", sig_a, sig_hold);
    ndone = 0;
    repeat (5) begin
      if (done_a || busy_a) ndone++;
      step();
    end
    check("ab_no_done", ndone, 0);

    // Full run with stim-dependent response and ignored start re-pulses.
    resp_mode = 1;
    golden_a = misr_model(1'b1);
    run_a(1'b1, nbusy, ndone, nerr);
    check("a2_busy_cycles", nbusy, 6144);
    check("a2_stim_steps", nerr, 0);
    check("a2_done", done_a, 1);
    step();
    check("a2_pass", pass_a, 1);
    check("a2_sig", sig_a, misr_model(1'b1));

    // Reset mid-run.
    start_a = 1; step(); start_a = 0;
    repeat (200) step();
    rst_n_a = 0; step(); rst_n_a = 1;
    check("mr_sig", sig_a, 16'h0000);
    check("mr_stim", stim_a, 0);
    check("mr_busy", busy_a, 0);
    check("mr_pass", pass_a, 0);
    ndone = 0;
    repeat (10) begin
      if (done_a || busy_a) ndone++;
      step();
    end
    check("mr_quiet", ndone, 0);

    // start and abort together in idle.
    start_a = 1; abort_a = 1; step(); start_a = 0; abort_a = 0;
    check("sa_busy", busy_a, 0);
    check("sa_stim", stim_a, 0);
    step();
    check("sa_busy2", busy_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
